// File: rtl/hdp_reg_sequencer_if.sv
// Command/response bus between a host and the HDP register sequencer.
// master = host side (offers commands, consumes responses),
// slave  = sequencer side.
interface hdp_reg_sequencer_if #(
    parameter int ADDR_WIDTH = 7
);
    // command channel
    logic                  i_cmd_valid;
    logic                  o_cmd_ready;
    logic                  i_cmd_read;
    logic [ADDR_WIDTH-1:0] i_cmd_addr;
    logic [7:0]            i_cmd_data;
    // response channel
    logic                  o_rsp_valid;
    logic                  i_rsp_ready;
    logic [7:0]            o_rsp_data;
    logic                  o_rsp_error;

    modport master (
        output i_cmd_valid, i_cmd_read, i_cmd_addr, i_cmd_data, i_rsp_ready,
        input  o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_error
    );

    modport slave (
        input  i_cmd_valid, i_cmd_read, i_cmd_addr, i_cmd_data, i_rsp_ready,
        output o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_error
    );
endinterface

// File: rtl/hdp_reg_sequencer.sv
// HDP register sequencer: turns single register read/write commands into
// one SPI transfer each ({rw,addr} then data byte), waits for the SPI
// engine's completion edge with a timeout, and returns a response.
// Optional feature macro: HDP_SEQ_WRITE_VERIFY_EN -- after every write,
// read the same register back and flag a mismatch as an error.
module hdp_reg_sequencer #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int ADDR_WIDTH     = 7
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    hdp_reg_sequencer_if.slave   bus,
    output logic                 o_spi_enable,
    output logic                 o_spi_start,
    output logic [7:0]           o_tx_upper,
    output logic [7:0]           o_tx_lower,
    input  logic                 i_spi_done,
    input  logic [7:0]           i_rx_lower
);

    // Counter only has to reach TIMEOUT_CYCLES-1.
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_RESPOND
`ifdef HDP_SEQ_WRITE_VERIFY_EN
        ,
        S_VERIFY_ISSUE,
        S_VERIFY_WAIT
`endif
    } state_t;

    state_t                state_q,     state_d;
    logic                  cmd_read_q,  cmd_read_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_q,  cmd_addr_d;
    logic [7:0]            cmd_data_q,  cmd_data_d;
    logic [7:0]            rsp_data_q,  rsp_data_d;
    logic                  rsp_error_q, rsp_error_d;
    logic [CNT_W-1:0]      tmo_cnt_q,   tmo_cnt_d;
    logic                  done_prev_q, done_prev_d;

    logic in_wait;
    logic issuing;
    logic verify_phase;
    logic done_evt;
    logic timeout;
    logic tx_rd_flag;

`ifdef HDP_SEQ_WRITE_VERIFY_EN
    assign in_wait      = (state_q == S_WAIT_DONE)  || (state_q == S_VERIFY_WAIT);
    assign issuing      = (state_q == S_ISSUE)      || (state_q == S_VERIFY_ISSUE);
    assign verify_phase = (state_q == S_VERIFY_ISSUE) || (state_q == S_VERIFY_WAIT);
`else
    assign in_wait      = (state_q == S_WAIT_DONE);
    assign issuing      = (state_q == S_ISSUE);
    assign verify_phase = 1'b0;
`endif

    // Only a fresh rising edge while waiting counts; a level already high on
    // entry is rejected because done_prev_q tracks the input every cycle.
    assign done_evt = in_wait && i_spi_done && !done_prev_q;
    assign timeout  = in_wait && (tmo_cnt_q == CNT_LAST);

    // Handshake/strobe outputs are forced low while reset is held so that
    // they are inactive even before the first reset edge settles the state.
    assign bus.o_cmd_ready = (state_q == S_IDLE)    && !i_reset;
    assign bus.o_rsp_valid = (state_q == S_RESPOND) && !i_reset;
    assign bus.o_rsp_data  = rsp_data_q;
    assign bus.o_rsp_error = rsp_error_q;
    assign o_spi_start     = issuing && !i_reset;
    assign o_spi_enable    = !i_reset;

    // SPI transmit bytes come straight from the command register, so they are
    // stable for the whole issue/wait window; verify phase forces a read frame.
    always_comb begin
        tx_rd_flag                  = cmd_read_q | verify_phase;
        o_tx_upper                  = 8'h00;
        o_tx_upper[7]               = tx_rd_flag;
        o_tx_upper[ADDR_WIDTH-1:0]  = cmd_addr_q;
        o_tx_lower                  = tx_rd_flag ? 8'h00 : cmd_data_q;
    end

    // Next-state and datapath updates for the command FSM.
    always_comb begin
        state_d     = state_q;
        cmd_read_d  = cmd_read_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;
        tmo_cnt_d   = tmo_cnt_q;
        done_prev_d = i_spi_done;

        case (state_q)
            S_IDLE: begin
                if (bus.i_cmd_valid) begin
                    cmd_read_d = bus.i_cmd_read;
                    cmd_addr_d = bus.i_cmd_addr;
                    cmd_data_d = bus.i_cmd_data;
                    state_d    = S_ISSUE;
                end
            end

            S_ISSUE: begin
                tmo_cnt_d = '0;
                state_d   = S_WAIT_DONE;
            end

            S_WAIT_DONE: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                // done wins over a coincident timeout
                if (done_evt) begin
                    if (cmd_read_q) begin
                        rsp_data_d = i_rx_lower;
                        state_d    = S_RESPOND;
                    end else begin
                        rsp_data_d = 8'h00;
`ifdef HDP_SEQ_WRITE_VERIFY_EN
                        state_d    = S_VERIFY_ISSUE;
`else
                        state_d    = S_RESPOND;
`endif
                    end
                end else if (timeout) begin
                    rsp_data_d  = 8'h00;
                    rsp_error_d = 1'b1;
                    state_d     = S_RESPOND;
                end
            end

`ifdef HDP_SEQ_WRITE_VERIFY_EN
            S_VERIFY_ISSUE: begin
                tmo_cnt_d = '0;
                state_d   = S_VERIFY_WAIT;
            end

            S_VERIFY_WAIT: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (done_evt) begin
                    rsp_data_d  = i_rx_lower;
                    rsp_error_d = (i_rx_lower != cmd_data_q);
                    state_d     = S_RESPOND;
                end else if (timeout) begin
                    rsp_error_d = 1'b1;
                    state_d     = S_RESPOND;
                end
            end
`endif

            S_RESPOND: begin
                if (bus.i_rsp_ready) begin
                    rsp_error_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any command in flight.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            cmd_read_q  <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= 8'h00;
            rsp_data_q  <= 8'h00;
            rsp_error_q <= 1'b0;
            tmo_cnt_q   <= '0;
            // treat done as high so a new edge needs the line to drop first
            done_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cmd_read_q  <= cmd_read_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
            tmo_cnt_q   <= tmo_cnt_d;
            done_prev_q <= done_prev_d;
        end
    end

endmodule

// File: tb/tb_hdp_reg_sequencer.sv
// Bench for hdp_reg_sequencer: table of command vectors plus hand-written
// sequences for held-done, done-high-on-entry, reset mid-transfer and (when
// HDP_SEQ_WRITE_VERIFY_EN is defined) write read-back verification.
module tb_hdp_reg_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_enable, spi_start, spi_done;
    logic [7:0] tx_upper, tx_lower, rx_lower;

    always #10 clk = ~clk;

    hdp_reg_sequencer_if #(.ADDR_WIDTH(7)) bus();

    hdp_reg_sequencer #(.TIMEOUT_CYCLES(4096), .ADDR_WIDTH(7)) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .bus          (bus),
        .o_spi_enable (spi_enable),
        .o_spi_start  (spi_start),
        .o_tx_upper   (tx_upper),
        .o_tx_lower   (tx_lower),
        .i_spi_done   (spi_done),
        .i_rx_lower   (rx_lower)
    );

    typedef struct {
        logic       rd;
        logic [6:0] addr;
        logic [7:0] data;
        logic [7:0] rx;
        int         dly;      // cycles in WAIT_DONE before done rises, -1 = never
        logic [7:0] exp_up;
        logic [7:0] exp_lo;
        logic [7:0] exp_data;
        logic       exp_err;
        logic       chk_data;
        int         exp_lat;  // cycles from entering WAIT_DONE to o_rsp_valid
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       err;
        logic       chk_data;
    } rsp_t;

    rsp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   start_cnt = 0;
    int   rsp_cnt = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endfunction

    // Count start pulses and check each consumed response against the scoreboard.
    always @(negedge clk) begin
        rsp_t e;
        if (spi_start === 1'b1) start_cnt++;
        if (bus.o_rsp_valid === 1'b1 && bus.i_rsp_ready === 1'b1) begin
            rsp_cnt++;
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL rsp_unexpected: got data 0x%0h, want no response", bus.o_rsp_data);
            end else begin
                e = sb.pop_front();
                if (e.chk_data) chk("rsp_data", 32'(bus.o_rsp_data), 32'(e.data));
                chk("rsp_error", 32'(bus.o_rsp_error), 32'(e.err));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic rd, input logic [6:0] addr, input logic [7:0] data);
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_read  = rd;
        bus.i_cmd_addr  = addr;
        bus.i_cmd_data  = data;
        chk("cmd_ready_idle", 32'(bus.o_cmd_ready), 32'd1);
        tick();
        // scramble the bus to prove the command was latched
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_read  = ~rd;
        bus.i_cmd_addr  = ~addr;
        bus.i_cmd_data  = ~data;
    endtask

    task automatic run_vec(input vec_t v);
        int s0, r0, n;
        s0 = start_cnt;
        r0 = rsp_cnt;
        sb.push_back('{v.exp_data, v.exp_err, v.chk_data});
        offer(v.rd, v.addr, v.data);
        // ISSUE: one cycle after accept
        chk("start_latency", 32'(spi_start), 32'd1);
        chk("tx_upper", 32'(tx_upper), 32'(v.exp_up));
        chk("tx_lower", 32'(tx_lower), 32'(v.exp_lo));
        chk("cmd_ready_busy", 32'(bus.o_cmd_ready), 32'd0);
        tick();
        chk("start_width", 32'(spi_start), 32'd0);
        n = 0;
        while (bus.o_rsp_valid !== 1'b1 && n < 5000) begin
            if (n == v.dly) begin
                spi_done = 1'b1;
                rx_lower = v.rx;
            end
            tick();
            n++;
        end
        chk("rsp_latency", 32'(n), 32'(v.exp_lat));
        chk("tx_upper_held", 32'(tx_upper), 32'(v.exp_up));
        bus.i_rsp_ready = 1'b1;
        tick();
        bus.i_rsp_ready = 1'b0;
        spi_done        = 1'b0;
        tick();
        chk("start_count", 32'(start_cnt - s0), 32'd1);
        chk("rsp_count", 32'(rsp_cnt - r0), 32'd1);
        chk("err_cleared", 32'(bus.o_rsp_error), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no end of test, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   s0, r0;

        //          rd    addr   data   rx     dly   up     lo     rdata  err   chkd  lat
        vecs[0] = '{1'b0, 7'h05, 8'hA5, 8'h00, 1100, 8'h05, 8'hA5, 8'h00, 1'b0, 1'b1, 1101};
        vecs[1] = '{1'b1, 7'h12, 8'h00, 8'h3C, 3,    8'h92, 8'h00, 8'h3C, 1'b0, 1'b1, 4};
        vecs[2] = '{1'b1, 7'h7F, 8'h77, 8'hFF, 0,    8'hFF, 8'h00, 8'hFF, 1'b0, 1'b1, 1};
        vecs[3] = '{1'b0, 7'h00, 8'hFF, 8'hAA, 4095, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1, 4096};
        vecs[4] = '{1'b0, 7'h33, 8'h5A, 8'h00, -1,   8'h33, 8'h5A, 8'h00, 1'b1, 1'b0, 4096};
        vecs[5] = '{1'b1, 7'h40, 8'h00, 8'h00, 4094, 8'hC0, 8'h00, 8'h00, 1'b0, 1'b1, 4095};
        vecs[6] = '{1'b1, 7'h01, 8'hEE, 8'h81, 7,    8'h81, 8'h00, 8'h81, 1'b0, 1'b1, 8};

        rst             = 1'b1;
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_read  = 1'b0;
        bus.i_cmd_addr  = 7'h00;
        bus.i_cmd_data  = 8'h00;
        bus.i_rsp_ready = 1'b0;
        spi_done        = 1'b0;
        rx_lower        = 8'h00;
        tick(3);

        // reset values
        chk("rst_cmd_ready", 32'(bus.o_cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
        chk("rst_spi_start", 32'(spi_start), 32'd0);
        chk("rst_spi_enable", 32'(spi_enable), 32'd0);
        chk("rst_tx_upper", 32'(tx_upper), 32'd0);
        chk("rst_tx_lower", 32'(tx_lower), 32'd0);
        chk("rst_rsp_data", 32'(bus.o_rsp_data), 32'd0);
        chk("rst_rsp_error", 32'(bus.o_rsp_error), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_enable", 32'(spi_enable), 32'd1);

        for (int i = 0; i < 7; i++) begin
`ifdef HDP_SEQ_WRITE_VERIFY_EN
            if (!vecs[i].rd) continue;
`endif
            run_vec(vecs[i]);
        end

        // done held high for 50 cycles with rsp_ready always high
        s0 = start_cnt;
        r0 = rsp_cnt;
        bus.i_rsp_ready = 1'b1;
        sb.push_back('{8'h11, 1'b0, 1'b1});
        offer(1'b1, 7'h22, 8'h00);
        tick();
        spi_done = 1'b1;
        rx_lower = 8'h11;
        tick(50);
        spi_done = 1'b0;
        tick(3);
        bus.i_rsp_ready = 1'b0;
        chk("held_done_starts", 32'(start_cnt - s0), 32'd1);
        chk("held_done_rsps", 32'(rsp_cnt - r0), 32'd1);

        // done already high on entry must not complete the transfer
        spi_done = 1'b1;
        tick(2);
        sb.push_back('{8'h5F, 1'b0, 1'b1});
        offer(1'b1, 7'h0A, 8'h00);
        rx_lower = 8'h5F;
        tick(11);
        chk("level_not_edge", 32'(bus.o_rsp_valid), 32'd0);
        spi_done = 1'b0;
        tick();
        spi_done = 1'b1;
        tick();
        chk("edge_after_low", 32'(bus.o_rsp_valid), 32'd1);
        bus.i_rsp_ready = 1'b1;
        tick();
        bus.i_rsp_ready = 1'b0;
        spi_done        = 1'b0;
        tick();

        // reset 500 cycles into WAIT_DONE abandons the command
        r0 = rsp_cnt;
        offer(1'b1, 7'h15, 8'h00);
        tick(501);
        rst = 1'b1;
        tick();
        chk("mid_rst_cmd_ready", 32'(bus.o_cmd_ready), 32'd0);
        chk("mid_rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
        chk("mid_rst_spi_start", 32'(spi_start), 32'd0);
        chk("mid_rst_spi_enable", 32'(spi_enable), 32'd0);
        chk("mid_rst_tx_upper", 32'(tx_upper), 32'd0);
        chk("mid_rst_tx_lower", 32'(tx_lower), 32'd0);
        chk("mid_rst_rsp_data", 32'(bus.o_rsp_data), 32'd0);
        chk("mid_rst_rsp_error", 32'(bus.o_rsp_error), 32'd0);
        tick();
        rst = 1'b0;
        tick(20);
        chk("no_rsp_after_rst", 32'(rsp_cnt - r0), 32'd0);
        run_vec(vecs[1]);

`ifdef HDP_SEQ_WRITE_VERIFY_EN
        // write 0x5A, read-back returns 0x58
        s0 = start_cnt;
        sb.push_back('{8'h58, 1'b1, 1'b1});
        offer(1'b0, 7'h05, 8'h5A);
        chk("vfy_tx_upper", 32'(tx_upper), 32'h05);
        chk("vfy_tx_lower", 32'(tx_lower), 32'h5A);
        tick();
        spi_done = 1'b1;
        rx_lower = 8'h00;
        tick();
        chk("vfy_start2", 32'(spi_start), 32'd1);
        chk("vfy_rd_upper", 32'(tx_upper), 32'h85);
        chk("vfy_rd_lower", 32'(tx_lower), 32'h00);
        spi_done = 1'b0;
        tick(2);
        spi_done = 1'b1;
        rx_lower = 8'h58;
        tick();
        chk("vfy_rsp_valid", 32'(bus.o_rsp_valid), 32'd1);
        bus.i_rsp_ready = 1'b1;
        tick();
        bus.i_rsp_ready = 1'b0;
        spi_done        = 1'b0;
        tick();
        chk("vfy_starts", 32'(start_cnt - s0), 32'd2);
`endif

        tick(2);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
